// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle for seg7_scan_mux: frame data and display controls in, registered
// segment/digit drive and frame marker out.
interface seg7_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] iValue;
    logic [DIGITS-1:0]   iDp;
    logic                iLzs;
    logic                iBlank;
    logic [7:0]          o7seg;
    logic [DIGITS-1:0]   oDigit;
    logic                oFrame;

    modport master (
        output iValue, iDp, iLzs, iBlank,
        input  o7seg, oDigit, oFrame
    );

    modport slave (
        input  iValue, iDp, iLzs, iBlank,
        output o7seg, oDigit, oFrame
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with a frame-coherent shadow register,
// per-digit decimal point, leading-zero suppression, blanking and anti-ghosting dead time.
module seg7_scan_mux #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 2,
    parameter int HEX_MODE = 0
) (
    input logic              iClk,
    input logic              iRst_n,
    seg7_scan_mux_if.slave   disp
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]       div_q;
    logic [IW-1:0]       idx_q;
    logic [4*DIGITS-1:0] shadow_val_q;
    logic [DIGITS-1:0]   shadow_dp_q;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   digit_q, digit_d;
    logic                frame_q;

    logic                last_div;
    logic                load;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_lz;
    logic                run_zero;
    logic                dead;
    logic [7:0]          glyph;

    assign last_div = (div_q == DW'(SCAN_DIV - 1));
    assign load     = (div_q == '0) && (idx_q == '0);

    function automatic logic [7:0] decode(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0:    g = 8'b00000011;
            4'h1:    g = 8'b10011111;
            4'h2:    g = 8'b00100101;
            4'h3:    g = 8'b00001101;
            4'h4:    g = 8'b10011001;
            4'h5:    g = 8'b01001001;
            4'h6:    g = 8'b01000001;
            4'h7:    g = 8'b00011111;
            4'h8:    g = 8'b00000001;
            4'h9:    g = 8'b00001001;
            default: g = 8'b10010001;
        endcase
        if (HEX_MODE != 0) begin
            case (n)
                4'hA:    g = 8'b00010001;
                4'hB:    g = 8'b11000001;
                4'hC:    g = 8'b01100011;
                4'hD:    g = 8'b10000101;
                4'hE:    g = 8'b01100001;
                4'hF:    g = 8'b01110001;
                default: ;
            endcase
        end
        return g;
    endfunction

    // Walk from the most significant digit down so run_zero means "this and all higher are 0".
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
        run_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run_zero = run_zero & (shadow_val_q[4*k +: 4] == 4'h0);
            if (idx_q == IW'(k)) begin
                cur_nib = shadow_val_q[4*k +: 4];
                cur_dp  = shadow_dp_q[k];
                cur_lz  = run_zero && (k != 0);
            end
        end
    end

    always_comb begin
        dead    = int'(div_q) < DEAD_CYC;
        glyph   = decode(cur_nib);
        digit_d = '1;
        seg_d   = 8'hFF;
        if (!(dead || disp.iBlank)) begin
            digit_d = ~(DIGITS'(1) << idx_q);
            if (disp.iLzs && cur_lz) begin
                glyph[7:1] = 7'h7F;
            end
            seg_d = {glyph[7:1], glyph[0] & ~cur_dp};
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            seg_q        <= 8'hFF;
            digit_q      <= '1;
            frame_q      <= 1'b0;
        end else begin
            if (last_div) begin
                div_q <= '0;
                idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            frame_q <= load;
            if (load) begin
                shadow_val_q <= disp.iValue;
                shadow_dp_q  <= disp.iDp;
            end
            seg_q   <= seg_d;
            digit_q <= digit_d;
        end
    end

    assign disp.o7seg  = seg_q;
    assign disp.oDigit = digit_q;
    assign disp.oFrame = frame_q;

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Holds one frame of BCD/hex nibbles and enables one digit at a time.
- Per-digit features: decimal point, leading-zero suppression, global blanking.
- Anti-ghosting dead time at the start of every digit slot.
- Generalises the single-digit decimal decoder: N digits, hex mode, frame-coherent shadow register.

Parameters:
DIGITS, 4, number of digits; legal 1..8.
SCAN_DIV, 50000, clock cycles per digit slot; ≥ 4.
DEAD_CYC, 2, cycles at start of each slot with all digits disabled; legal 0..SCAN_DIV-2.
HEX_MODE, 0, 1 = nibbles 10..15 show A b C d E F; 0 = show error glyph.

Ports:
iClk  input  1  system clock, rising edge.
iRst_n  input  1  asynchronous active-low reset.
iValue  input  4*DIGITS  nibble k = digit k; digit 0 is least significant.
iDp  input  DIGITS  1 = light decimal point of digit k.
iLzs  input  1  1 = suppress leading zeros.
iBlank  input  1  1 = display dark; sampled live.
o7seg  output  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered.
oDigit  output  DIGITS  digit enables, active-low, one-hot-low or all-high, registered.
oFrame  output  1  one-cycle pulse marking shadow load.

Behaviour:
- Reset (asynchronous, iRst_n=0): div=0, idx=0, shadow value=0, shadow dp=0, o7seg=8'hFF, oDigit=all 1, oFrame=0.
- Divider:
  - div counts 0..SCAN_DIV-1.
  - When div==SCAN_DIV-1: div<=0 and idx<=idx+1, wrapping DIGITS-1 -> 0.
  - idx width = max(1, clog2(DIGITS)).
- Frame length = DIGITS*SCAN_DIV cycles.
- Shadow load:
  - On any edge where div==0 and idx==0, shadow captures iValue and iDp. This includes the first edge after reset release.
  - oFrame=1 in the following cycle, 0 otherwise.
  - iValue/iDp changes mid-frame are invisible until the next load (no tearing).
- Outputs are registered from the current (div, idx, shadow, iBlank, iLzs), giving 1-cycle latency.
  - Dead time (div<DEAD_CYC) or iBlank=1: oDigit=all 1, o7seg=8'hFF.
  - Otherwise: oDigit = all 1 except bit idx = 0; o7seg = decode(shadow nibble idx), with bit0 forced to 0 if shadow dp[idx]=1.
- Decode, 0..9: 00000011, 10011111, 00100101, 00001101, 10011001, 01001001, 01000001, 00011111, 00000001, 00001001.
- Decode, 10..15:
  - HEX_MODE=1: A=00010001, b=11000001, C=01100011, d=10000101, E=01100001, F=01110001.
  - HEX_MODE=0: all 10..15 give the error glyph 10010001.
- Leading-zero suppression:
  - Applies when iLzs=1, k≠0, and shadow nibbles DIGITS-1..k are all zero.
  - Segments a..g of digit k are off (bits 7:1 = 1). dp is still honoured.
  - The digit enable still pulses.
  - Digit 0 is never suppressed.
- iBlank and iLzs are not shadowed. They take effect on the next output register update and do not disturb div or idx.
- Reset mid-frame: outputs return to reset values immediately. Scanning restarts at digit 0 with a fresh shadow load.

Test Plan:
1. Setup DIGITS=4, SCAN_DIV=8, DEAD_CYC=2, iValue=16'h1234, iDp=0; hold reset then release -> during reset o7seg=FF, oDigit=1111. oFrame pulses at cycle 1 and every 32 cycles. Slot 0 (after 2 dead cycles, +1 latency): oDigit=1110, o7seg=10011001. Slot 3: oDigit=0111, o7seg=10011111.
2. iValue=16'hABCD -> digit0 = 10000101 with HEX_MODE=1, 10010001 with HEX_MODE=0. Digit3 = 00010001 with HEX_MODE=1.
3. iLzs=1, iValue=16'h0050 -> digits 3,2 o7seg=FF with enables still pulsing; digit1=01001001; digit0=00000011. iValue=0 -> only digit0 shows 00000011.
4. iValue changed 16'h1111->16'h2222 in slot 1 -> remaining slots show 10011111. From the next frame all digits show 00100101.
5. iDp=4'b0010 -> digit1 o7seg=00001100. iBlank raised mid-slot -> next cycle oDigit=1111, o7seg=FF. Lowering iBlank resumes at the correct idx/div phase.
6. iRst_n pulled low in slot 2 -> o7seg=FF, oDigit=1111, oFrame=0 without waiting for a clock edge. After release, first lit slot is digit 0 with the newly loaded value.
